// File: rtl/enemy_tank_ai.sv
// Autonomous driver for one enemy tank: spawn delay, pseudo-random patrol with
// occasional chase toward a target, pause-and-turn after collisions, cooldown-limited fire.
module enemy_tank_ai #(
   parameter int          SPAWN_DELAY   = 60,
   parameter int          MOVE_MIN      = 16,
   parameter int          TURN_PAUSE    = 8,
   parameter int          FIRE_COOLDOWN = 45,
   parameter int          ALIGN_TOL     = 8,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic       frame_clk,
   input  logic       Reset_n,
   input  logic       enable,
   input  logic       blocked,
   input  logic [9:0] TankX,
   input  logic [9:0] TankY,
   input  logic [9:0] target_x,
   input  logic [9:0] target_y,
   input  logic       bullet_active,
   output logic       move_up,
   output logic       move_down,
   output logic       move_left,
   output logic       move_right,
   output logic       fire,
   output logic [1:0] ai_state
);

   localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
   localparam logic [15:0] LFSR_MASK = 16'hB400;

   typedef enum logic [1:0] {ST_SPAWN = 2'b00, ST_PATROL = 2'b01, ST_PAUSE = 2'b10} state_t;
   typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_t;

   state_t      state, state_n;
   dir_t        cur_dir, cur_dir_n, last_dir, last_dir_n;
   dir_t        pick, pick_rot;
   logic [7:0]  spawn_cnt, spawn_cnt_n;
   logic [7:0]  seg_cnt, seg_cnt_n;
   logic [7:0]  pause_cnt, pause_cnt_n;
   logic [7:0]  cooldown, cooldown_n;
   logic [7:0]  seg_load;
   logic [15:0] lfsr, lfsr_n;
   logic [3:0]  moves, moves_n;
   logic        fire_q, fire_n;
   logic signed [10:0] dx, dy;
   logic [10:0] adx, ady;
   logic        aligned;

   // Move vector is ordered {up, down, left, right}
   function automatic logic [3:0] dir_moves(input dir_t d);
      case (d)
         DIR_UP:   dir_moves = 4'b1000;
         DIR_DOWN: dir_moves = 4'b0100;
         DIR_LEFT: dir_moves = 4'b0010;
         default:  dir_moves = 4'b0001;
      endcase
   endfunction

   function automatic dir_t rotate(input dir_t d);
      case (d)
         DIR_UP:   rotate = DIR_LEFT;
         DIR_LEFT: rotate = DIR_DOWN;
         DIR_DOWN: rotate = DIR_RIGHT;
         default:  rotate = DIR_UP;
      endcase
   endfunction

   // Offsets are widened by one bit so the full 10-bit range never wraps
   assign dx       = $signed({1'b0, target_x}) - $signed({1'b0, TankX});
   assign dy       = $signed({1'b0, target_y}) - $signed({1'b0, TankY});
   assign adx      = dx[10] ? 11'(-dx) : 11'(dx);
   assign ady      = dy[10] ? 11'(-dy) : 11'(dy);
   assign aligned  = (adx < 11'(ALIGN_TOL)) || (ady < 11'(ALIGN_TOL));
   assign seg_load = 8'(MOVE_MIN) + {2'b00, lfsr[9:4]};

   always_comb begin
      pick = dir_t'(lfsr[1:0]);
      if ((lfsr[3:2] == 2'b00) && ((dx != 11'sd0) || (dy != 11'sd0))) begin
         if (ady >= adx) pick = dy[10] ? DIR_UP : DIR_DOWN;
         else            pick = dx[10] ? DIR_LEFT : DIR_RIGHT;
      end
      pick_rot = (pick == last_dir) ? rotate(pick) : pick;
   end

   always_comb begin
      state_n     = state;
      cur_dir_n   = cur_dir;
      last_dir_n  = last_dir;
      spawn_cnt_n = spawn_cnt;
      seg_cnt_n   = seg_cnt;
      pause_cnt_n = pause_cnt;
      cooldown_n  = cooldown;
      moves_n     = moves;
      fire_n      = 1'b0;
      lfsr_n      = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_MASK : 16'h0000);

      if (!enable) begin
         state_n     = ST_SPAWN;
         spawn_cnt_n = 8'(SPAWN_DELAY);
         moves_n     = 4'b0000;
      end else begin
         case (state)
            ST_SPAWN: begin
               moves_n = 4'b0000;
               if (spawn_cnt == 8'd0) begin
                  state_n   = ST_PATROL;
                  cur_dir_n = pick;
                  moves_n   = dir_moves(pick);
                  seg_cnt_n = seg_load;
               end else begin
                  spawn_cnt_n = spawn_cnt - 8'd1;
               end
            end
            ST_PATROL: begin
               if (blocked) begin
                  state_n     = ST_PAUSE;
                  moves_n     = 4'b0000;
                  pause_cnt_n = 8'(TURN_PAUSE - 1);
                  last_dir_n  = cur_dir;
               end else if (seg_cnt == 8'd0) begin
                  cur_dir_n = pick;
                  moves_n   = dir_moves(pick);
                  seg_cnt_n = seg_load;
               end else begin
                  seg_cnt_n = seg_cnt - 8'd1;
               end
            end
            ST_PAUSE: begin
               moves_n = 4'b0000;
               if (pause_cnt == 8'd0) begin
                  state_n   = ST_PATROL;
                  cur_dir_n = pick_rot;
                  moves_n   = dir_moves(pick_rot);
                  seg_cnt_n = seg_load;
               end else begin
                  pause_cnt_n = pause_cnt - 8'd1;
               end
            end
            default: begin
               state_n = ST_SPAWN;
               moves_n = 4'b0000;
            end
         endcase

         // Cooldown only runs while the tank is live on the field
         if ((state == ST_PATROL) || (state == ST_PAUSE)) begin
            cooldown_n = (cooldown == 8'd0) ? 8'd0 : cooldown - 8'd1;
            if ((cooldown == 8'd0) && !bullet_active && !fire_q &&
                (aligned || (lfsr[15:12] == 4'h0))) begin
               fire_n     = 1'b1;
               cooldown_n = 8'(FIRE_COOLDOWN);
            end
         end
      end
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= ST_SPAWN;
         cur_dir   <= DIR_UP;
         last_dir  <= DIR_UP;
         spawn_cnt <= 8'(SPAWN_DELAY);
         seg_cnt   <= 8'd0;
         pause_cnt <= 8'd0;
         cooldown  <= 8'd0;
         moves     <= 4'b0000;
         fire_q    <= 1'b0;
         lfsr      <= SEED;
      end else begin
         state     <= state_n;
         cur_dir   <= cur_dir_n;
         last_dir  <= last_dir_n;
         spawn_cnt <= spawn_cnt_n;
         seg_cnt   <= seg_cnt_n;
         pause_cnt <= pause_cnt_n;
         cooldown  <= cooldown_n;
         moves     <= moves_n;
         fire_q    <= fire_n;
         lfsr      <= lfsr_n;
      end
   end

   assign {move_up, move_down, move_left, move_right} = moves;
   assign fire     = fire_q;
   assign ai_state = state;

endmodule
